// File: rtl/decode_stage_ctrl.sv
// Decode-stage sequencer: owns IF/ID and ID/EX, inserts one load-use bubble, handles flush.
// Optional load-use stall counter enabled by defining STALL_CNT_EN.
module decode_stage_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             id_ready,
    output logic [31:0]      imm_instr,
    input  logic [31:0]      imm_in,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [31:0]      ex_instr,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_imm,
    output logic [2:0]       ex_imm_fmt,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StEmpty, StFull, StStall} state_e;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    state_e      state_q, state_d;
    logic [31:0] id_instr_q, id_instr_d, id_pc_q, id_pc_d;
    logic        ex_valid_q, ex_valid_d, ex_illegal_q, ex_illegal_d;
    logic [31:0] ex_instr_q, ex_instr_d, ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
    logic [2:0]  ex_fmt_q, ex_fmt_d;

    logic [2:0]  id_fmt;
    logic        id_illegal, use_rs1, use_rs2;
    logic        hazard, load_use, issue;

    always_comb begin
        id_fmt     = FMT_NONE;
        id_illegal = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (id_instr_q[6:0])
            7'b0000011, 7'b1100111, 7'b0010011: begin
                id_fmt  = FMT_I;
                use_rs1 = 1'b1;
            end
            7'b0100011: begin
                id_fmt  = FMT_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1100011: begin
                id_fmt  = FMT_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: id_fmt = FMT_U;
            7'b1101111:             id_fmt = FMT_J;
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: id_illegal = 1'b1;
        endcase
    end

    // Only evaluated in FULL: in STALL the load has already moved past EX.
    assign hazard = (state_q == StFull) && ex_valid_q && (ex_instr_q[6:0] == OP_LOAD) &&
                    (ex_instr_q[11:7] != 5'd0) &&
                    ((use_rs1 && (ex_instr_q[11:7] == id_instr_q[19:15])) ||
                     (use_rs2 && (ex_instr_q[11:7] == id_instr_q[24:20])));

    assign load_use = !flush && ex_ready && hazard;
    assign issue    = !flush && ex_ready &&
                      (((state_q == StFull) && !hazard) || (state_q == StStall));
    assign id_ready = !flush && ((state_q == StEmpty) || issue);

    always_comb begin
        state_d      = state_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        ex_valid_d   = ex_valid_q;
        ex_instr_d   = ex_instr_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_fmt_d     = ex_fmt_q;
        ex_illegal_d = ex_illegal_q;

        if (flush || load_use || ((state_q == StEmpty) && ex_ready)) begin
            ex_valid_d   = 1'b0;
            ex_instr_d   = NOP_INSTR;
            ex_imm_d     = '0;
            ex_fmt_d     = FMT_NONE;
            ex_illegal_d = 1'b0;
        end

        if (flush) begin
            state_d    = StEmpty;
            id_instr_d = NOP_INSTR;
        end else begin
            if (load_use) state_d = StStall;
            if (issue) begin
                ex_valid_d   = 1'b1;
                ex_instr_d   = id_instr_q;
                ex_pc_d      = id_pc_q;
                ex_imm_d     = (id_fmt == FMT_NONE) ? '0 : imm_in;
                ex_fmt_d     = id_fmt;
                ex_illegal_d = id_illegal;
                state_d      = StEmpty;
            end
            if (id_ready && if_valid) begin
                id_instr_d = if_instr;
                id_pc_d    = if_pc;
                state_d    = StFull;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StEmpty;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= '0;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= NOP_INSTR;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_fmt_q     <= FMT_NONE;
            ex_illegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            ex_valid_q   <= ex_valid_d;
            ex_instr_q   <= ex_instr_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
            ex_fmt_q     <= ex_fmt_d;
            ex_illegal_q <= ex_illegal_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (load_use && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

    assign imm_instr  = id_instr_q;
    assign ex_valid   = ex_valid_q;
    assign ex_instr   = ex_instr_q;
    assign ex_pc      = ex_pc_q;
    assign ex_imm     = ex_imm_q;
    assign ex_imm_fmt = ex_fmt_q;
    assign ex_illegal = ex_illegal_q;

endmodule
